// File: rtl/led_ctrl_pkg.sv
// Shared mode encoding and mode-advance helper for the LED pattern controller.
package led_ctrl_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF    = 3'd0,
        MODE_SOLID  = 3'd1,
        MODE_BLINK  = 3'd2,
        MODE_CHASE  = 3'd3,
        MODE_BOUNCE = 3'd4
    } mode_e;

    // Next mode for a given current mode; illegal codes fall back to OFF.
    function automatic mode_e next_mode(input mode_e cur, input logic adv);
        mode_e nxt;
        nxt = MODE_OFF;
        case (cur)
            MODE_OFF:    nxt = adv ? MODE_SOLID  : MODE_OFF;
            MODE_SOLID:  nxt = adv ? MODE_BLINK  : MODE_SOLID;
            MODE_BLINK:  nxt = adv ? MODE_CHASE  : MODE_BLINK;
            MODE_CHASE:  nxt = adv ? MODE_BOUNCE : MODE_CHASE;
            MODE_BOUNCE: nxt = adv ? MODE_OFF    : MODE_BOUNCE;
            default:     nxt = MODE_OFF;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchroniser followed by a rising-edge detector.
// One input pulse of any width gives a single-cycle rise_c_o.
module pulse_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic rise_c_o
);

    logic [2:0] sh_q;
    logic [2:0] sh_d;

    // Shift the raw input through s1, s2, s3.
    always_comb begin
        sh_d = {sh_q[1:0], d_i};
    end

    // Synchroniser and edge-history registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sh_q <= 3'b000;
        end else begin
            sh_q <= sh_d;
        end
    end

    // Rising edge: s2 high while s3 still low.
    assign rise_c_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/led_pattern_ctrl.sv
// Mode FSM, pattern prescaler and LED pattern generator driven by a
// debounced press input.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned N_LEDS   = 4,
    parameter int unsigned TICK_DIV = 12500000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_press,
    output logic [N_LEDS-1:0] o_led,
    output logic [MODE_W-1:0] o_mode
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    logic              press_evt_c;
    logic              tick_c;
    logic [POS_W-1:0]  step_c;

    mode_e             mode_q,  mode_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              phase_q, phase_d;
    logic [POS_W-1:0]  pos_q,   pos_d;
    logic              dir_q,   dir_d;
    logic [N_LEDS-1:0] led_q,   led_d;

    pulse_sync u_press_sync (
        .clk_i    (i_clk),
        .rst_n_i  (i_rst_n),
        .d_i      (i_press),
        .rise_c_o (press_evt_c)
    );

    assign tick_c = (cnt_q == CNT_MAX);

    // Next mode, prescaler, pattern state and LED image.
    always_comb begin
        mode_d  = mode_q;
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        step_c  = pos_q;
        led_d   = '0;

        mode_d = next_mode(mode_q, press_evt_c);

        if (press_evt_c || tick_c) begin
            cnt_d = '0;
        end

        if (press_evt_c) begin
            // A press restarts every pattern from its entry value.
            phase_d = 1'b1;
            pos_d   = '0;
            dir_d   = DIR_UP;
        end else if (tick_c) begin
            case (mode_q)
                MODE_BLINK: begin
                    phase_d = ~phase_q;
                end
                MODE_CHASE: begin
                    pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
                end
                MODE_BOUNCE: begin
                    if (N_LEDS > 1) begin
                        step_c = (dir_q == DIR_DOWN) ? pos_q - POS_W'(1)
                                                     : pos_q + POS_W'(1);
                        pos_d  = step_c;
                        if (step_c == POS_MAX) begin
                            dir_d = DIR_DOWN;
                        end else if (step_c == '0) begin
                            dir_d = DIR_UP;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        // LED image follows the next-state values so it moves with o_mode.
        case (mode_d)
            MODE_SOLID:  led_d = '1;
            MODE_BLINK:  led_d = {N_LEDS{phase_d}};
            MODE_CHASE,
            MODE_BOUNCE: led_d = N_LEDS'(1) << pos_d;
            default:     led_d = '0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q  <= MODE_OFF;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            pos_q   <= '0;
            dir_q   <= DIR_UP;
            led_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
        end
    end

    assign o_led  = led_q;
    assign o_mode = mode_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl with TICK_DIV=4, N_LEDS=4.
// Stimulus pushes {edge index, mode, led} expectations; the monitor
// compares on the falling edge after that rising edge.
module tb_led_pattern_ctrl;

    typedef struct {
        int          cyc;
        logic [2:0]  mode;
        logic [3:0]  led;
        string       name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       press;
    logic [3:0] led;
    logic [2:0] mode;

    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    led_pattern_ctrl #(
        .N_LEDS   (4),
        .TICK_DIV (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_press (press),
        .o_led   (led),
        .o_mode  (mode)
    );

    always #5 clk = ~clk;

    // Rising-edge index: after edge K, cyc == K.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int c,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, c, act, req);
        end
    endtask

    task automatic push(input int c, input logic [2:0] m, input logic [3:0] l,
                        input string nm);
        exp_t e;
        e.cyc  = c;
        e.mode = m;
        e.led  = l;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: pop every expectation due at this edge index and compare.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s missed cyc=%0d now=%0d", e.name, e.cyc, cyc);
            end else begin
                check({e.name, ".mode"}, e.cyc, 32'(mode), 32'(e.mode));
                check({e.name, ".led"},  e.cyc, 32'(led),  32'(e.led));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step();
    endtask

    // One-cycle press; returns the edge index where the new mode appears.
    task automatic advance(output int t);
        t = cyc + 3;
        press = 1'b1;
        step();
        press = 1'b0;
        step_to(t);
    endtask

    localparam logic [3:0] CHASE_SEQ [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    localparam logic [3:0] BOUNCE_SEQ[8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                             4'b0100, 4'b0010, 4'b0001, 4'b0010};

    initial begin
        int t;
        int r;
        rst_n = 1'b0;
        press = 1'b0;

        // Reset held with press toggling: outputs stay at zero.
        for (int i = 0; i < 5; i++) begin
            step();
            press = ~press;
            check("rst_hold.mode", cyc, 32'(mode), 32'd0);
            check("rst_hold.led",  cyc, 32'(led),  32'd0);
        end
        press = 1'b0;
        step();
        rst_n = 1'b1;
        r = cyc;
        push(r + 1, 3'd0, 4'b0000, "post_rst");
        push(r + 4, 3'd0, 4'b0000, "post_rst");
        step_to(r + 5);

        // Wide press: exactly one advance, two-edge latency.
        t = cyc + 3;
        push(t - 1, 3'd0, 4'b0000, "wide_latency");
        for (int k = 0; k <= 12; k++) push(t + k, 3'd1, 4'b1111, "wide_solid");
        press = 1'b1;
        repeat (10) step();
        press = 1'b0;
        step_to(t + 13);

        // BLINK: on at entry, off after one tick period, on again after two.
        advance(t);
        push(t,     3'd2, 4'b1111, "blink");
        push(t + 3, 3'd2, 4'b1111, "blink");
        push(t + 4, 3'd2, 4'b0000, "blink");
        push(t + 7, 3'd2, 4'b0000, "blink");
        push(t + 8, 3'd2, 4'b1111, "blink");
        step_to(t + 9);

        // CHASE walking one-hot with wrap.
        advance(t);
        for (int k = 0; k < 5; k++) begin
            push(t + 4 * k, 3'd3, CHASE_SEQ[k], "chase");
            if (k < 4) push(t + 4 * k + 3, 3'd3, CHASE_SEQ[k], "chase_hold");
        end
        step_to(t + 17);

        // BOUNCE back and forth.
        advance(t);
        for (int k = 0; k < 8; k++) push(t + 4 * k, 3'd4, BOUNCE_SEQ[k], "bounce");
        step_to(t + 29);

        // Fifth press wraps to OFF.
        advance(t);
        push(t,     3'd0, 4'b0000, "wrap");
        push(t + 4, 3'd0, 4'b0000, "wrap");
        step_to(t + 5);

        // Press landing on a CHASE tick at pos=2: BOUNCE entry, no stray step.
        advance(t);
        advance(t);
        advance(t);
        push(t,     3'd3, 4'b0001, "corner_chase");
        push(t + 4, 3'd3, 4'b0010, "corner_chase");
        push(t + 8, 3'd3, 4'b0100, "corner_chase");
        step_to(t + 9);
        press = 1'b1;
        step();
        press = 1'b0;
        push(t + 11, 3'd3, 4'b0100, "corner_pre");
        push(t + 12, 3'd4, 4'b0001, "corner_entry");
        push(t + 15, 3'd4, 4'b0001, "corner_hold");
        push(t + 16, 3'd4, 4'b0010, "corner_step");
        step_to(t + 17);

        // Asynchronous reset between edges mid-CHASE.
        advance(t);
        advance(t);
        advance(t);
        advance(t);
        push(t,     3'd3, 4'b0001, "async_chase");
        push(t + 4, 3'd3, 4'b0010, "async_chase");
        step_to(t + 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.led",  cyc, 32'(led),  32'd0);
        check("async_rst.mode", cyc, 32'(mode), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        r = cyc;
        push(r + 1, 3'd0, 4'b0000, "async_after");
        push(r + 4, 3'd0, 4'b0000, "async_after");
        step_to(r + 5);
        advance(t);
        push(t, 3'd1, 4'b1111, "restart_solid");
        step_to(t + 1);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
